// File: rtl/arb_pkg.sv
// Shared constants and types for the 4-way round-robin arbiter.
// Optional grant timeout is enabled by GRANT_TIMEOUT_EN.
package arb_pkg;

  localparam int N_REQ    = 4;
  localparam int IDX_W    = 2;
  localparam int MAX_HOLD = 8;
  localparam int HOLD_W   =
    (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [N_REQ-1:0]  req_t;
  typedef logic [HOLD_W-1:0] hold_t;

endpackage

// File: rtl/rr_arbiter_4_pick.sv
// Rotated priority picker: first set request at or after ptr.
// Pure combinational; wraps modulo 4.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_vld
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest offset down so the nearest one wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr;
    idx      = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter feeding a 2:4 decoder, break-before-make.
// Define GRANT_TIMEOUT_EN to add the MAX_HOLD forced release.
module rr_arbiter_4
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  input  logic             ack_in,
  output logic [IDX_W-1:0] gnt_idx_out,
  output logic             gnt_en_out,
  output logic             busy_out,
  output logic             timeout_out
);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             rel;
  logic             to_hit;
  logic             to_pulse;

  rr_pick u_pick (
    .req      (req_in),
    .ptr      (ptr),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

`ifdef GRANT_TIMEOUT_EN
  hold_t hold_cnt;

  assign to_hit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt    <= '0;
      timeout_out <= 1'b0;
    end else begin
      timeout_out <= to_pulse;
      if (state == IDLE)
        hold_cnt <= '0;
      else if (!to_hit)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // Timeout only reports when it is the sole reason to release.
  assign to_pulse = (state == GRANT) && to_hit
                  && !ack_in && req_in[gnt_idx_out];

  always_comb begin
    state_nxt = state;
    rel       = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_vld)
          state_nxt = GRANT;
      end
      GRANT: begin
        if (ack_in || !req_in[gnt_idx_out] || to_hit) begin
          state_nxt = IDLE;
          rel       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt_idx_out <= '0;
      ptr         <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_vld)
        gnt_idx_out <= pick_idx;
      if (rel)
        ptr <= gnt_idx_out + 1'b1;
    end
  end

  assign gnt_en_out = (state == GRANT);
  assign busy_out   = (state == GRANT);

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4.
// Timeout expectations follow GRANT_TIMEOUT_EN.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic       ack_in;
  logic [1:0] gnt_idx_out;
  logic       gnt_en_out;
  logic       busy_out;
  logic       timeout_out;

  int checks = 0;
  int errors = 0;

  rr_arbiter_4 dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .ack_in      (ack_in),
    .gnt_idx_out (gnt_idx_out),
    .gnt_en_out  (gnt_en_out),
    .busy_out    (busy_out),
    .timeout_out (timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] dec();
    return gnt_en_out ? (4'b0001 << gnt_idx_out) : 4'b0000;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_in = 4'b1111; ack_in = 1'b0;
    tick(); tick();
    checks++;
    if (gnt_en_out !== 1'b0) begin
      errors++; $display("FAIL rst_en got %b exp 0", gnt_en_out);
    end
    checks++;
    if (gnt_idx_out !== 2'd0) begin
      errors++; $display("FAIL rst_idx got %0d exp 0", gnt_idx_out);
    end
    checks++;
    if (busy_out !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b exp 0", busy_out);
    end
    checks++;
    if (timeout_out !== 1'b0) begin
      errors++; $display("FAIL rst_to got %b exp 0", timeout_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt_en_out !== 1'b1 || gnt_idx_out !== 2'd0 || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL first_gnt got en=%b idx=%0d busy=%b exp 1/0/1",
               gnt_en_out, gnt_idx_out, busy_out);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_idx [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      checks++;
      if (gnt_en_out !== 1'b0 || dec() !== 4'b0000) begin
        errors++;
        $display("FAIL rot_gap%0d got en=%b dec=%b exp 0/0000",
                 i, gnt_en_out, dec());
      end
      tick();
      checks++;
      if (gnt_en_out !== 1'b1 || gnt_idx_out !== exp_idx[i]) begin
        errors++;
        $display("FAIL rot_gnt%0d got en=%b idx=%0d exp 1/%0d",
                 i, gnt_en_out, gnt_idx_out, exp_idx[i]);
      end
    end
  endtask

  task automatic test_priority_skip();
    ack_in = 1'b1; req_in = 4'b1001;
    tick();
    ack_in = 1'b0;
    tick();
    checks++;
    if (gnt_en_out !== 1'b1 || gnt_idx_out !== 2'd3) begin
      errors++;
      $display("FAIL skip_to3 got en=%b idx=%0d exp 1/3",
               gnt_en_out, gnt_idx_out);
    end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    tick();
    checks++;
    if (gnt_en_out !== 1'b1 || gnt_idx_out !== 2'd0) begin
      errors++;
      $display("FAIL skip_wrap0 got en=%b idx=%0d exp 1/0",
               gnt_en_out, gnt_idx_out);
    end
    ack_in = 1'b1; req_in = 4'b0000;
    tick();
    ack_in = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    req_in = 4'b0100;
    tick();
    checks++;
    if (gnt_en_out !== 1'b1 || gnt_idx_out !== 2'd2) begin
      errors++;
      $display("FAIL wd_gnt2 got en=%b idx=%0d exp 1/2",
               gnt_en_out, gnt_idx_out);
    end
    req_in = 4'b0000;
    tick();
    checks++;
    if (gnt_en_out !== 1'b0 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL wd_release got en=%b busy=%b exp 0/0",
               gnt_en_out, busy_out);
    end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checks++;
    if (gnt_en_out !== 1'b0 || busy_out !== 1'b0 || gnt_idx_out !== 2'd2) begin
      errors++;
      $display("FAIL idle_ack got en=%b busy=%b idx=%0d exp 0/0/2",
               gnt_en_out, busy_out, gnt_idx_out);
    end
    req_in = 4'b1111;
    tick();
    checks++;
    if (gnt_en_out !== 1'b1 || gnt_idx_out !== 2'd3) begin
      errors++;
      $display("FAIL wd_ptr3 got en=%b idx=%0d exp 1/3",
               gnt_en_out, gnt_idx_out);
    end
    req_in = 4'b1011;
    tick();
    checks++;
    if (gnt_en_out !== 1'b1 || gnt_idx_out !== 2'd3) begin
      errors++;
      $display("FAIL other_req got en=%b idx=%0d exp 1/3",
               gnt_en_out, gnt_idx_out);
    end
    req_in = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    req_in = 4'b0010;
    tick();
    checks++;
    if (gnt_en_out !== 1'b1 || gnt_idx_out !== 2'd1) begin
      errors++;
      $display("FAIL to_gnt got en=%b idx=%0d exp 1/1",
               gnt_en_out, gnt_idx_out);
    end
`ifdef GRANT_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (gnt_en_out !== 1'b1 || timeout_out !== 1'b0) begin
        errors++;
        $display("FAIL to_hold%0d got en=%b to=%b exp 1/0",
                 i, gnt_en_out, timeout_out);
      end
    end
    tick();
    checks++;
    if (gnt_en_out !== 1'b0 || timeout_out !== 1'b1) begin
      errors++;
      $display("FAIL to_fire got en=%b to=%b exp 0/1",
               gnt_en_out, timeout_out);
    end
    tick();
    checks++;
    if (gnt_en_out !== 1'b1 || gnt_idx_out !== 2'd1 || timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL to_regnt got en=%b idx=%0d to=%b exp 1/1/0",
               gnt_en_out, gnt_idx_out, timeout_out);
    end
`else
    for (int i = 1; i < 56; i++) begin
      tick();
      checks++;
      if (gnt_en_out !== 1'b1 || timeout_out !== 1'b0) begin
        errors++;
        $display("FAIL no_to%0d got en=%b to=%b exp 1/0",
                 i, gnt_en_out, timeout_out);
      end
    end
`endif
    req_in = 4'b0000;
    tick();
  endtask

  task automatic test_mid_reset();
    req_in = 4'b0100;
    tick();
    checks++;
    if (gnt_en_out !== 1'b1 || gnt_idx_out !== 2'd2) begin
      errors++;
      $display("FAIL mr_gnt2 got en=%b idx=%0d exp 1/2",
               gnt_en_out, gnt_idx_out);
    end
    rst = 1'b1; req_in = 4'b0110;
    tick();
    rst = 1'b0;
    checks++;
    if (gnt_en_out !== 1'b0 || busy_out !== 1'b0 || gnt_idx_out !== 2'd0) begin
      errors++;
      $display("FAIL mr_rst got en=%b busy=%b idx=%0d exp 0/0/0",
               gnt_en_out, busy_out, gnt_idx_out);
    end
    tick();
    checks++;
    if (gnt_en_out !== 1'b1 || gnt_idx_out !== 2'd1) begin
      errors++;
      $display("FAIL mr_ptr0 got en=%b idx=%0d exp 1/1",
               gnt_en_out, gnt_idx_out);
    end
  endtask

  initial begin
    rst = 1'b1; req_in = 4'b0000; ack_in = 1'b0;
    test_reset();
    test_rotation();
    test_priority_skip();
    test_withdraw();
    test_timeout();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
